ws2812_frame_sched: RTL and testbench
=====================================

Name: ws2812_frame_sched

Overview:
- Frame-level scheduler in front of the WS2812 serial controller.
- Decides when a new frame transmission starts, either on host frame commit or on a periodic auto-refresh timer.
- Issues the single-cycle frame-ready strobe to the controller.
- Owns double-buffer bank selection between the host write path and the controller read path, and reports overrun and start-timeout errors.

Parameters:
- TICK_DIV, 2000: clk_in cycles per refresh tick (10 µs at 200 MHz).
- START_TO, 16: max cycles from frame_rdy_out until ctl_busy_in must rise.
- FCNT_W, 8: width of frame_cnt_out.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- host_done_in  input  1  one-cycle pulse: host finished writing a frame into the write bank
- ctl_busy_in  input  1  high while the serial controller is outside its init state (frame plus reset code in progress)
- auto_en_in  input  1  enable periodic refresh
- period_in  input  16  refresh period in ticks; 0 disables auto refresh
- err_clr_in  input  1  one-cycle pulse clearing the sticky error flags
- frame_rdy_out  output  1  one-cycle start strobe to the controller
- wr_bank_out  output  1  bank the host writes
- rd_bank_out  output  1  bank the controller reads; always equal to ~wr_bank_out
- frame_cnt_out  output  FCNT_W  frames started, wraps modulo 2^FCNT_W
- overrun_out  output  1  sticky: host_done_in arrived while a host frame was still pending
- timeout_out  output  1  sticky: controller did not go busy within START_TO cycles

Behaviour:
- Reset values: frame_rdy_out=0, wr_bank_out=0, rd_bank_out=1, frame_cnt_out=0, overrun_out=0, timeout_out=0. Internally: state IDLE, pending=0, tick prescaler=0, period timer=0.
- Reset asserted mid-frame aborts immediately to reset values. The controller's own reset is separate and not driven by this block.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and emits a tick on the TICK_DIV-1 cycle.
  - Free-running whenever out of reset.
- Period timer:
  - Counts ticks.
  - On the tick where timer+1 >= period_in, raises auto_req, provided auto_en_in=1 and period_in!=0.
  - Cleared in the START cycle.
  - Holds at 0 while auto refresh is disabled.
- Host frame commit:
  - host_done_in sets pending (host_req).
  - If pending is already 1 in that cycle, overrun_out is set and pending stays 1 (frames merge).
- State machine:
  - IDLE: if pending or auto_req, and ctl_busy_in=0, go to START next cycle. If ctl_busy_in=1, stay in IDLE.
  - START, exactly one cycle:
    - frame_rdy_out=1 and frame_cnt_out increments.
    - If pending=1, wr_bank_out toggles (rd_bank_out follows) on this edge and pending clears.
    - auto_req clears and the timeout counter is loaded with 0.
    - Next state is WAIT_BUSY.
  - WAIT_BUSY:
    - When ctl_busy_in=1, go to RUN.
    - When the counter reaches START_TO-1 with busy still 0, set timeout_out and return to IDLE (frame abandoned, bank swap not undone).
  - RUN: when ctl_busy_in=0, return to IDLE.
- Latency: request to frame_rdy_out is 2 cycles when idle (register request, IDLE to START).
- Simultaneous host_done_in and auto_req produce one frame with a swap; auto_req is consumed.
- host_done_in during WAIT_BUSY or RUN sets pending. The frame is served on the next IDLE pass with no swap mid-frame, so the bank never changes while the controller reads.
- auto_req during RUN is held and served after RUN.
- err_clr_in clears both sticky flags. If a set and a clear occur in the same cycle, set wins.
- frame_cnt_out wraps from 2^FCNT_W-1 to 0.

Decomposition:
- Package ws2812_pkg holds:
  - the scheduler state enum (IDLE, START, WAIT_BUSY, RUN);
  - the default TICK_DIV and START_TO constants;
  - the bank index typedef.
- One sub-module, ws2812_tick_gen: the TICK_DIV prescaler with a one-cycle tick output.

Test Plan:
- Host pulse at idle, ctl_busy_in rises 3 cycles after the strobe and falls 100 cycles later -> frame_rdy_out high exactly at cycle +2, wr_bank_out 0->1, rd_bank_out 1->0, frame_cnt_out=1, no error flags.
- auto_en_in=1, period_in=3, TICK_DIV=4 (sim override), controller echoes busy for 5 cycles -> frame_rdy_out every 12 cycles, banks never toggle.
- Two host pulses 10 cycles apart while in RUN -> overrun_out=1, exactly one extra frame after busy drops, one bank toggle; err_clr_in then clears overrun_out.
- Host pulse and auto tick expiry in the same cycle -> single frame_rdy_out, single swap, frame_cnt_out increments by 1.
- ctl_busy_in held 0 after the strobe -> timeout_out=1 at START_TO cycles after frame_rdy_out, state back in IDLE, next host pulse still starts a frame.
- rst_n_in asserted during RUN -> all outputs at reset values immediately; after release, a fresh host pulse produces frame_cnt_out=1 and wr_bank_out=1.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing constants for the WS2812 frame scheduler.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_RUN       = 2'd3
  } sched_state_e;

  localparam int unsigned TICK_DIV_DEF = 2000;
  localparam int unsigned START_TO_DEF = 16;

  typedef logic bank_t;

endpackage

// File: rtl/ws2812_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clk_in cycles.
module ws2812_tick_gen
  import ws2812_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic tick_out
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler counter, wraps after the tick cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick_out = (r_cnt == LAST);

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler: starts frames on host commit or auto-refresh, owns the
// double-buffer bank select and reports overrun / start-timeout errors.
module ws2812_frame_sched
  import ws2812_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned START_TO = START_TO_DEF,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              host_done_in,
  input  logic              ctl_busy_in,
  input  logic              auto_en_in,
  input  logic [15:0]       period_in,
  input  logic              err_clr_in,
  output logic              frame_rdy_out,
  output logic              wr_bank_out,
  output logic              rd_bank_out,
  output logic [FCNT_W-1:0] frame_cnt_out,
  output logic              overrun_out,
  output logic              timeout_out
);

  localparam int unsigned     TO_W    = $clog2(START_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  sched_state_e      r_state;
  logic              r_pending;
  logic              r_auto_req;
  logic [15:0]       r_timer;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_frame_rdy;
  bank_t             r_wr_bank;
  bank_t             r_rd_bank;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_overrun;
  logic              r_timeout;

  logic              w_tick;
  logic              w_auto_on;
  logic              w_start;
  logic              w_to_expire;
  logic              w_ovr_set;
  logic [16:0]       w_timer_inc;

  ws2812_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tick_out (w_tick)
  );

  assign w_auto_on   = auto_en_in && (period_in != 16'd0);
  assign w_start     = (r_state == ST_IDLE) && (r_pending || r_auto_req) && !ctl_busy_in;
  assign w_to_expire = (r_state == ST_WAIT_BUSY) && !ctl_busy_in && (r_to_cnt == TO_LAST);
  assign w_ovr_set   = host_done_in && r_pending;
  assign w_timer_inc = {1'b0, r_timer} + 17'd1;

  // Host commit latch; a commit arriving in the start cycle stays pending.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= host_done_in || (r_pending && !w_start);
    end
  end

  // Period timer; holds the request once raised until a frame consumes it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_timer    <= 16'd0;
      r_auto_req <= 1'b0;
    end else if (!w_auto_on || w_start) begin
      r_timer    <= 16'd0;
      r_auto_req <= 1'b0;
    end else if (w_tick && !r_auto_req) begin
      r_timer <= w_timer_inc[15:0];
      if (w_timer_inc >= {1'b0, period_in}) begin
        r_auto_req <= 1'b1;
      end
    end
  end

  // Scheduler FSM with registered strobe, bank select and frame counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_IDLE;
      r_frame_rdy <= 1'b0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b1;
      r_frame_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_frame_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_START;
            r_frame_rdy <= 1'b1;
            r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
            r_to_cnt    <= '0;
            // Swap only for host frames, and only while the controller is idle.
            if (r_pending) begin
              r_wr_bank <= ~r_wr_bank;
              r_rd_bank <= r_wr_bank;
            end
          end
        end
        ST_START: begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
          r_state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (ctl_busy_in) begin
            r_state <= ST_RUN;
          end else if (r_to_cnt == TO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_RUN: begin
          if (!ctl_busy_in) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr_in) begin
        r_overrun <= 1'b0;
      end
      if (w_to_expire) begin
        r_timeout <= 1'b1;
      end else if (err_clr_in) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign frame_rdy_out = r_frame_rdy;
  assign wr_bank_out   = r_wr_bank;
  assign rd_bank_out   = r_rd_bank;
  assign frame_cnt_out = r_frame_cnt;
  assign overrun_out   = r_overrun;
  assign timeout_out   = r_timeout;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Self-checking bench for ws2812_frame_sched with a behavioural frame model.
module tb_ws2812_frame_sched;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned START_TO = 16;
  localparam int unsigned FCNT_W   = 8;

  logic        clk_in       = 1'b0;
  logic        rst_n_in     = 1'b0;
  logic        host_done_in = 1'b0;
  logic        ctl_busy_in  = 1'b0;
  logic        auto_en_in   = 1'b0;
  logic [15:0] period_in    = 16'd0;
  logic        err_clr_in   = 1'b0;
  logic        frame_rdy_out;
  logic        wr_bank_out;
  logic        rd_bank_out;
  logic [7:0]  frame_cnt_out;
  logic        overrun_out;
  logic        timeout_out;

  int errors = 0;
  int checks = 0;

  ws2812_frame_sched #(
    .TICK_DIV (TICK_DIV),
    .START_TO (START_TO),
    .FCNT_W   (FCNT_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .host_done_in  (host_done_in),
    .ctl_busy_in   (ctl_busy_in),
    .auto_en_in    (auto_en_in),
    .period_in     (period_in),
    .err_clr_in    (err_clr_in),
    .frame_rdy_out (frame_rdy_out),
    .wr_bank_out   (wr_bank_out),
    .rd_bank_out   (rd_bank_out),
    .frame_cnt_out (frame_cnt_out),
    .overrun_out   (overrun_out),
    .timeout_out   (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: frame bookkeeping in terms of edges since reset.
  int unsigned m_n, m_ticks, m_start;
  bit          m_pend, m_auto, m_bank, m_ovr, m_to, m_rdy, m_active, m_busy_seen;
  logic [7:0]  m_cnt;

  // Controller emulation (stimulus only).
  bit resp_en;
  int resp_delay, resp_len, rs;
  int rdy_seen, wr_toggles;
  bit prev_wr;

  logic [12:0] dut_v, exp_v;
  assign dut_v = {frame_rdy_out, wr_bank_out, rd_bank_out, frame_cnt_out, overrun_out, timeout_out};
  assign exp_v = {m_rdy, m_bank, ~m_bank, m_cnt, m_ovr, m_to};

  task automatic model_reset();
    m_n = 0; m_ticks = 0; m_start = 0;
    m_pend = 0; m_auto = 0; m_bank = 0; m_ovr = 0; m_to = 0;
    m_rdy = 0; m_active = 0; m_busy_seen = 0; m_cnt = 8'd0;
  endtask

  task automatic model_step();
    bit start, tick, en, to_set, ovr_set;
    tick    = (m_n % TICK_DIV) == (TICK_DIV - 1);
    en      = auto_en_in && (period_in != 16'd0);
    start   = !m_active && (m_pend || m_auto) && !ctl_busy_in;
    to_set  = 0;
    ovr_set = host_done_in && m_pend;
    if (m_active && (m_n >= m_start + 2)) begin
      if (m_busy_seen) begin
        if (!ctl_busy_in) m_active = 0;
      end else if (ctl_busy_in) begin
        m_busy_seen = 1;
      end else if (m_n - m_start == START_TO) begin
        to_set = 1; m_active = 0;
      end
    end
    if (start) begin
      if (m_pend) m_bank = !m_bank;
      m_cnt = m_cnt + 8'd1;
      m_active = 1; m_busy_seen = 0; m_start = m_n;
    end
    m_pend = host_done_in || (m_pend && !start);
    if (!en || start) begin
      m_ticks = 0; m_auto = 0;
    end else if (tick && !m_auto) begin
      m_ticks = m_ticks + 1;
      if (m_ticks >= period_in) m_auto = 1;
    end
    m_rdy = start;
    if (ovr_set) m_ovr = 1; else if (err_clr_in) m_ovr = 0;
    if (to_set) m_to = 1; else if (err_clr_in) m_to = 0;
    m_n = m_n + 1;
  endtask

  task automatic resp_update();
    if (!resp_en) begin
      rs = -1; ctl_busy_in = 1'b0;
    end else begin
      if (frame_rdy_out) rs = 0;
      else if (rs >= 0) rs = rs + 1;
      ctl_busy_in = (rs >= resp_delay) && (rs < resp_delay + resp_len);
      if (rs >= resp_delay + resp_len) rs = -1;
    end
  endtask

  task automatic tick_cycle();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    if (frame_rdy_out) rdy_seen++;
    if (wr_bank_out != prev_wr) wr_toggles++;
    prev_wr = wr_bank_out;
    resp_update();
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0; host_done_in = 1'b0; err_clr_in = 1'b0;
    auto_en_in = 1'b0; period_in = 16'd0;
    resp_en = 0; rs = -1; ctl_busy_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    rdy_seen = 0; wr_toggles = 0; prev_wr = 1'b0;
  endtask

  task automatic pulse_host();
    host_done_in = 1'b1;
    tick_cycle();
    host_done_in = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_v !== 13'h0400) begin
      errors++; $display("FAIL reset_values got=%h exp=%h", dut_v, 13'h0400);
    end
    repeat (6) tick_cycle();
    checks++;
    if (dut_v !== 13'h0400) begin
      errors++; $display("FAIL reset_idle got=%h exp=%h", dut_v, 13'h0400);
    end
  endtask

  task automatic test_host_frame();
    apply_reset();
    resp_en = 1; resp_delay = 3; resp_len = 100;
    pulse_host();
    checks++;
    if (frame_rdy_out !== 1'b0) begin
      errors++; $display("FAIL host_rdy_early got=%b exp=0", frame_rdy_out);
    end
    tick_cycle();
    checks++;
    if ({frame_rdy_out, wr_bank_out, rd_bank_out, frame_cnt_out} !== {3'b110, 8'd1}) begin
      errors++; $display("FAIL host_start got rdy=%b wr=%b rd=%b cnt=%0d exp rdy=1 wr=1 rd=0 cnt=1",
                         frame_rdy_out, wr_bank_out, rd_bank_out, frame_cnt_out);
    end
    repeat (110) tick_cycle();
    checks++;
    if ({rdy_seen, overrun_out, timeout_out, wr_bank_out} !== {32'd1, 3'b001}) begin
      errors++; $display("FAIL host_after got frames=%0d ovr=%b to=%b wr=%b exp 1 0 0 1",
                         rdy_seen, overrun_out, timeout_out, wr_bank_out);
    end
  endtask

  task automatic test_auto_period();
    int idx[$];
    apply_reset();
    resp_en = 1; resp_delay = 1; resp_len = 5;
    auto_en_in = 1'b1; period_in = 16'd3;
    for (int i = 0; i < 90; i++) begin
      tick_cycle();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL auto_model cyc=%0d got=%h exp=%h", i, dut_v, exp_v);
      end
      if (frame_rdy_out) idx.push_back(i);
    end
    checks++;
    if (idx.size() != 7 || idx[0] != 12) begin
      errors++; $display("FAIL auto_count got n=%0d first=%0d exp n=7 first=12", idx.size(),
                         (idx.size() > 0) ? idx[0] : -1);
    end
    for (int k = 1; k < idx.size(); k++) begin
      checks++;
      if (idx[k] - idx[k-1] != 12) begin
        errors++; $display("FAIL auto_interval k=%0d got=%0d exp=12", k, idx[k] - idx[k-1]);
      end
    end
    checks++;
    if (wr_toggles != 0) begin
      errors++; $display("FAIL auto_banks got toggles=%0d exp=0", wr_toggles);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    resp_en = 1; resp_delay = 2; resp_len = 40;
    pulse_host();
    repeat (12) tick_cycle();
    pulse_host();
    repeat (9) tick_cycle();
    pulse_host();
    checks++;
    if (overrun_out !== 1'b1) begin
      errors++; $display("FAIL overrun_set got=%b exp=1", overrun_out);
    end
    repeat (100) tick_cycle();
    checks++;
    if (rdy_seen != 2 || wr_toggles != 2 || wr_bank_out !== 1'b0 || overrun_out !== 1'b1) begin
      errors++; $display("FAIL overrun_frames got frames=%0d toggles=%0d wr=%b ovr=%b exp 2 2 0 1",
                         rdy_seen, wr_toggles, wr_bank_out, overrun_out);
    end
    err_clr_in = 1'b1;
    tick_cycle();
    err_clr_in = 1'b0;
    checks++;
    if (overrun_out !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got=%b exp=0", overrun_out);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    resp_en = 1; resp_delay = 1; resp_len = 3;
    auto_en_in = 1'b1; period_in = 16'd3;
    repeat (11) tick_cycle();
    pulse_host();
    tick_cycle();
    checks++;
    if ({frame_rdy_out, wr_bank_out, frame_cnt_out} !== {2'b11, 8'd1}) begin
      errors++; $display("FAIL simul_start got rdy=%b wr=%b cnt=%0d exp 1 1 1",
                         frame_rdy_out, wr_bank_out, frame_cnt_out);
    end
    repeat (10) tick_cycle();
    checks++;
    if (rdy_seen != 1 || wr_toggles != 1 || frame_cnt_out !== 8'd1) begin
      errors++; $display("FAIL simul_single got frames=%0d toggles=%0d cnt=%0d exp 1 1 1",
                         rdy_seen, wr_toggles, frame_cnt_out);
    end
  endtask

  task automatic test_timeout();
    int k;
    apply_reset();
    pulse_host();
    k = 0;
    while (!frame_rdy_out && k < 10) begin
      tick_cycle(); k++;
    end
    checks++;
    if (!frame_rdy_out) begin
      errors++; $display("FAIL timeout_strobe got=0 exp=1 within 10 cycles");
    end
    for (int i = 1; i <= 16; i++) begin
      tick_cycle();
      if (i == 15) begin
        checks++;
        if (timeout_out !== 1'b0) begin
          errors++; $display("FAIL timeout_early got=%b exp=0", timeout_out);
        end
      end
    end
    checks++;
    if (timeout_out !== 1'b1) begin
      errors++; $display("FAIL timeout_set got=%b exp=1", timeout_out);
    end
    pulse_host();
    tick_cycle();
    checks++;
    if ({frame_rdy_out, wr_bank_out, frame_cnt_out, timeout_out} !== {2'b10, 8'd2, 1'b1}) begin
      errors++; $display("FAIL timeout_restart got rdy=%b wr=%b cnt=%0d to=%b exp 1 0 2 1",
                         frame_rdy_out, wr_bank_out, frame_cnt_out, timeout_out);
    end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    resp_en = 1; resp_delay = 2; resp_len = 100;
    pulse_host();
    repeat (12) tick_cycle();
    pulse_host();
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_v !== 13'h0400) begin
      errors++; $display("FAIL reset_mid_run got=%h exp=%h", dut_v, 13'h0400);
    end
    resp_en = 0; rs = -1; ctl_busy_in = 1'b0; host_done_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    prev_wr = 1'b0; rdy_seen = 0; wr_toggles = 0;
    resp_en = 1;
    pulse_host();
    tick_cycle();
    checks++;
    if ({frame_rdy_out, wr_bank_out, rd_bank_out, frame_cnt_out} !== {3'b110, 8'd1}) begin
      errors++; $display("FAIL reset_fresh got rdy=%b wr=%b rd=%b cnt=%0d exp 1 1 0 1",
                         frame_rdy_out, wr_bank_out, rd_bank_out, frame_cnt_out);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    resp_en = 1; resp_delay = 1; resp_len = 1;
    for (int i = 0; i < 256; i++) begin
      pulse_host();
      for (int c = 0; c < 7; c++) begin
        tick_cycle();
        checks++;
        if (dut_v !== exp_v) begin
          errors++; $display("FAIL wrap_model frame=%0d got=%h exp=%h", i, dut_v, exp_v);
        end
      end
    end
    checks++;
    if (rdy_seen != 256 || frame_cnt_out !== 8'd0 || wr_bank_out !== 1'b0 || overrun_out !== 1'b0) begin
      errors++; $display("FAIL wrap_end got frames=%0d cnt=%0d wr=%b ovr=%b exp 256 0 0 0",
                         rdy_seen, frame_cnt_out, wr_bank_out, overrun_out);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        auto_en_in = 1'($urandom_range(0, 1));
        period_in  = 16'($urandom_range(0, 6));
        resp_en    = ($urandom_range(0, 4) != 0);
        resp_delay = $urandom_range(1, 20);
        resp_len   = $urandom_range(1, 30);
      end
      host_done_in = ($urandom_range(0, 19) == 0);
      err_clr_in   = ($urandom_range(0, 29) == 0);
      tick_cycle();
      checks++;
      if (dut_v !== exp_v) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_v, exp_v);
      end
    end
    host_done_in = 1'b0; err_clr_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_host_frame();
    test_auto_period();
    test_overrun();
    test_simultaneous();
    test_timeout();
    test_reset_mid_run();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
